// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI burst master.
// Contents:
//   state_t      - burst master FSM states
//   ST_*         - completion status codes reported on 'status'
//   RESP_ERR     - responder error code on BRESP/RRESP
//   BURST_*      - burst type encodings (1-bit write channel form)
//   resp_status  - maps an error flag onto a completion status code
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    WD,
    WB,
    AR,
    RD,
    FIN
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] RESP_ERR = 2'b10;

  localparam logic BURST_FIXED = 1'b0;
  localparam logic BURST_INCR  = 1'b1;

  function automatic logic [1:0] resp_status(input logic err);
    return err ? ST_SLVERR : ST_OK;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI channel bundle used between the burst master and a responder.
// Channels: AW (address/burst/len), W (data/last), B (resp),
//           AR (address/burst/len), R (data/resp/last).
// Modports: master (initiator side), slave (responder side).
interface axi_burst_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWBURST;
  logic [7:0]            AWLEN;

  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;

  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [1:0]            ARBURST;
  logic [7:0]            ARLEN;

  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;

  modport master (
    output AWVALID, AWADDR, AWBURST, AWLEN,
    input  AWREADY,
    output WVALID, WDATA, WLAST,
    input  WREADY,
    input  BVALID, BRESP,
    output BREADY,
    output ARVALID, ARADDR, ARBURST, ARLEN,
    input  ARREADY,
    input  RVALID, RDATA, RRESP, RLAST,
    output RREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWBURST, AWLEN,
    output AWREADY,
    input  WVALID, WDATA, WLAST,
    output WREADY,
    output BVALID, BRESP,
    input  BREADY,
    input  ARVALID, ARADDR, ARBURST, ARLEN,
    output ARREADY,
    output RVALID, RDATA, RRESP, RLAST,
    input  RREADY
  );

endinterface

// File: rtl/axi_watchdog.sv
// Stall watchdog for the burst master.
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   clear  in  hold counter at zero (master idle or finishing)
//   kick   in  channel progress this cycle, restarts the count
//   expire out asserted in the TIMEOUT_CYC-th consecutive stalled cycle
module axi_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic kick,
  output logic expire
);

  localparam int            CW   = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_reg;

  // Saturates at LAST so a stalled counter can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || kick) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The cycle with count LAST is the TIMEOUT_CYC-th stalled cycle in a state;
  // the abort transition taken at its end makes the stall exactly TIMEOUT_CYC long.
  assign expire = !clear && !kick && (count_reg == LAST);

endmodule

// File: rtl/axi_burst_master.sv
// Single-burst AXI initiator: one user command becomes one write or read burst.
// Ports:
//   ACLK, ARESETn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write/addr/len/incr        command fields, registered on accept
//   usr_wvalid/wready/wdata        user write stream (passed through in WD)
//   usr_rvalid/rready/rdata/rlast  user read stream (passed through in RD)
//   done, status                   one-cycle completion pulse, held status code
//   axi                            AXI channel bundle, master side
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  cmd_incr,
  input  logic                  usr_wvalid,
  output logic                  usr_wready,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  output logic                  usr_rvalid,
  input  logic                  usr_rready,
  output logic [DATA_WIDTH-1:0] usr_rdata,
  output logic                  usr_rlast,
  output logic                  done,
  output logic [1:0]            status,
  axi_burst_master_if.master    axi
);

  state_t                state_reg;
  logic                  cmd_ready_reg;
  logic                  aw_valid_reg;
  logic                  ar_valid_reg;
  logic                  b_ready_reg;
  logic                  done_reg;
  logic [1:0]            status_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic                  incr_reg;
  logic [7:0]            beat_cnt_reg;
  logic                  err_reg;

  logic in_wd;
  logic in_rd;
  logic wlast;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic wd_clear;
  logic wd_kick;
  logic wd_expire;
  logic r_err;

  assign in_wd = (state_reg == WD);
  assign in_rd = (state_reg == RD);

  // Data phases are combinational pass-throughs gated by state, so the
  // user stream and the AXI channel see each other's flow control directly.
  assign wlast       = in_wd && (beat_cnt_reg == len_reg);
  assign axi.WVALID  = in_wd && usr_wvalid;
  assign axi.WDATA   = usr_wdata;
  assign axi.WLAST   = wlast;
  assign usr_wready  = in_wd && axi.WREADY;

  assign axi.RREADY  = in_rd && usr_rready;
  assign usr_rvalid  = in_rd && axi.RVALID;
  assign usr_rdata   = axi.RDATA;
  assign usr_rlast   = in_rd && axi.RLAST;

  assign axi.AWVALID = aw_valid_reg;
  assign axi.AWADDR  = addr_reg;
  assign axi.AWBURST = incr_reg ? BURST_INCR : BURST_FIXED;
  assign axi.AWLEN   = len_reg;
  assign axi.BREADY  = b_ready_reg;
  assign axi.ARVALID = ar_valid_reg;
  assign axi.ARADDR  = addr_reg;
  assign axi.ARBURST = {1'b0, incr_reg ? BURST_INCR : BURST_FIXED};
  assign axi.ARLEN   = len_reg;

  assign cmd_ready = cmd_ready_reg;
  assign done      = done_reg;
  assign status    = status_reg;

  assign aw_hs = aw_valid_reg && axi.AWREADY;
  assign w_hs  = axi.WVALID && axi.WREADY;
  assign b_hs  = axi.BVALID && b_ready_reg;
  assign ar_hs = ar_valid_reg && axi.ARREADY;
  assign r_hs  = axi.RVALID && axi.RREADY;
  assign r_err = (axi.RRESP == RESP_ERR);

  // Every transition between active states is caused by a handshake, which
  // already restarts the count; holding it clear in IDLE/FIN covers entry.
  assign wd_clear = (state_reg == IDLE) || (state_reg == FIN);
  assign wd_kick  = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  axi_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .clear (wd_clear),
    .kick  (wd_kick),
    .expire(wd_expire)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b0;
      aw_valid_reg  <= 1'b0;
      ar_valid_reg  <= 1'b0;
      b_ready_reg   <= 1'b0;
      done_reg      <= 1'b0;
      status_reg    <= ST_OK;
      addr_reg      <= '0;
      len_reg       <= '0;
      incr_reg      <= 1'b0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            addr_reg      <= cmd_addr;
            len_reg       <= cmd_len;
            incr_reg      <= cmd_incr;
            beat_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            if (cmd_write) begin
              state_reg    <= AW;
              aw_valid_reg <= 1'b1;
            end else begin
              state_reg    <= AR;
              ar_valid_reg <= 1'b1;
            end
          end
        end

        AW: begin
          if (aw_hs) begin
            aw_valid_reg <= 1'b0;
            state_reg    <= WD;
          end else if (wd_expire) begin
            aw_valid_reg <= 1'b0;
            status_reg   <= ST_TIMEOUT;
            done_reg     <= 1'b1;
            state_reg    <= FIN;
          end
        end

        WD: begin
          if (w_hs) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            if (wlast) begin
              b_ready_reg <= 1'b1;
              state_reg   <= WB;
            end
          end else if (wd_expire) begin
            status_reg <= ST_TIMEOUT;
            done_reg   <= 1'b1;
            state_reg  <= FIN;
          end
        end

        WB: begin
          if (b_hs) begin
            b_ready_reg <= 1'b0;
            status_reg  <= resp_status(axi.BRESP == RESP_ERR);
            done_reg    <= 1'b1;
            state_reg   <= FIN;
          end else if (wd_expire) begin
            b_ready_reg <= 1'b0;
            status_reg  <= ST_TIMEOUT;
            done_reg    <= 1'b1;
            state_reg   <= FIN;
          end
        end

        AR: begin
          if (ar_hs) begin
            ar_valid_reg <= 1'b0;
            state_reg    <= RD;
          end else if (wd_expire) begin
            ar_valid_reg <= 1'b0;
            status_reg   <= ST_TIMEOUT;
            done_reg     <= 1'b1;
            state_reg    <= FIN;
          end
        end

        RD: begin
          // Termination follows RLAST alone; the beat count is informational.
          if (r_hs) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            if (r_err) begin
              err_reg <= 1'b1;
            end
            if (axi.RLAST) begin
              status_reg <= resp_status(err_reg || r_err);
              done_reg   <= 1'b1;
              state_reg  <= FIN;
            end
          end else if (wd_expire) begin
            status_reg <= ST_TIMEOUT;
            done_reg   <= 1'b1;
            state_reg  <= FIN;
          end
        end

        FIN: begin
          cmd_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI-style initiator that turns one user command into a single write or read burst on the team's AXI channel set (1-bit AWBURST, 2-bit ARBURST, 8-bit LEN).
- Sits between a processor-side command port and memory-mapped responders such as the on-chip AXI RAM.
- Streams write data in and read data out through valid/ready user ports.
- Reports completion with a status code and guards every phase with a stall watchdog.

Parameters:
- ADDR_WIDTH, 16, AXI address width (word address)
- DATA_WIDTH, 32, AXI data width
- TIMEOUT_CYC, 1024, idle cycles without channel progress before abort (≥2)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  burst base address
- cmd_len  in  8  AXI LEN; beats = cmd_len+1
- cmd_incr  in  1  1=incrementing, 0=fixed
- usr_wvalid / usr_wready  in / out  1  user write stream handshake
- usr_wdata  in  DATA_WIDTH  write beat
- usr_rvalid / usr_rready  out / in  1  user read stream handshake
- usr_rdata  out  DATA_WIDTH  read beat
- usr_rlast  out  1  last read beat
- done  out  1  one-cycle completion pulse
- status  out  2  00 ok, 01 responder error, 10 timeout; held until next done
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH, AWBURST out 1, AWLEN out 8
- WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WLAST out 1
- BVALID in 1, BREADY out 1, BRESP in 2
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH, ARBURST out 2, ARLEN out 8
- RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2, RLAST in 1

Behaviour:
- Reset (ARESETn=0 at ACLK edge): state IDLE; all VALID/READY outputs, done, status, WLAST, and address/len/burst registers cleared to 0.
- Reset mid-burst aborts immediately. No done pulse.
- FSM states and transitions:
  - IDLE -> AW (write) or AR (read) on cmd_valid & cmd_ready. Command fields are registered in that cycle.
  - AW: AWVALID=1 with registered AWADDR/AWBURST=cmd_incr/AWLEN held stable until AWVALID&AWREADY -> WD. AWVALID drops the next cycle.
  - WD: WVALID = usr_wvalid; usr_wready = WREADY; WDATA = usr_wdata (combinational pass-through). Beat counter starts at 0 and increments per WVALID&WREADY. WLAST = (count == len). Handshake with WLAST -> WB.
  - WB: BREADY held 1 until BVALID; the responder raises BVALID only while BREADY is high. Then status = (BRESP==2'b10) ? 01 : 00 -> FIN.
  - AR: ARVALID=1 with ARBURST={1'b0,cmd_incr}, stable until ARVALID&ARREADY -> RD.
  - RD: RREADY = usr_rready; usr_rvalid = RVALID; usr_rdata = RDATA; usr_rlast = RLAST. Any beat with RRESP==2'b10 sets a sticky error flag. Beat handshake with RLAST -> FIN, status = error ? 01 : 00.
  - FIN: done=1 for one cycle -> IDLE. cmd_ready returns high the following cycle.
- Read termination is by RLAST only. Beat count is informational; a count mismatch is not an error.
- Watchdog: counter clears on entering each non-IDLE state and on any channel handshake; otherwise it increments. Reaching TIMEOUT_CYC -> FIN with status 10. All VALID/READY outputs drop in FIN.
- Outside its state, each VALID/READY output is 0. usr_wready=0 and usr_rvalid=0 except in WD/RD respectively.
- Simultaneous cmd_valid in FIN is not accepted: cmd_ready=0 there.
- len=0 gives a single beat with WLAST on the first beat.

Decomposition:
- Package axi_pkg:
  - state enum (IDLE, AW, WD, WB, AR, RD, FIN)
  - status constants ST_OK=2'b00, ST_SLVERR=2'b01, ST_TIMEOUT=2'b10
  - RESP_ERR=2'b10 and burst codes BURST_FIXED=0, BURST_INCR=1
- Sub-module axi_watchdog: counter with clear/kick inputs and an expire output, parameterised by TIMEOUT_CYC.

Test Plan:
- Write incr, addr 0x0010, len 3, data 0xA0..0xA3, slave BRESP 2'b01 -> 4 W beats, WLAST only on beat 4, done with status 00; a readback burst returns 0xA0..0xA3.
- Read incr, addr 0x0010, len 3, usr_rready toggling 1/0 -> RREADY mirrors it, 4 beats delivered in order, usr_rlast with 0xA3, status 00.
- Write to addr 0x0400 (out of range on the 1024-word RAM) -> BRESP 2'b10 sampled, status 01.
- Read with responder holding ARREADY=0, TIMEOUT_CYC=16 -> ARVALID held 16 cycles, then done with status 10 and ARVALID=0.
- ARESETn low during WD beat 2 -> next cycle all outputs 0, state IDLE, cmd_ready=1 after release, no done pulse.
- Write fixed, len 0, data 0x55 -> single beat with WLAST=1 and AWBURST=0, status 00.
